// File: rtl/amm_pkg.sv
// Shared definitions for the Avalon-MM DDR responder: FSM state encodings and
// the only legal burst length.
package amm_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_STALL = 2'd2
  } amm_state_e;

  localparam logic [5:0] AMM_BURST_ONE = 6'd1;

endpackage

// File: rtl/amm_rd_pipe.sv
// Valid/data delay line for read returns. Each stage only loads data when its
// incoming valid is set, so the last stage holds the previous word between pulses.
module amm_rd_pipe #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [DEPTH:0]   vld_c;
  logic [WIDTH-1:0] dat_c [DEPTH+1];
  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  assign vld_c[0] = in_valid_i;
  assign dat_c[0] = in_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign vld_c[gi+1] = vld_q[gi];
      assign dat_c[gi+1] = dat_q[gi];

      always_ff @(posedge clk) begin
        if (!rst_n_i) begin
          vld_q[gi] <= 1'b0;
          dat_q[gi] <= '0;
        end else begin
          vld_q[gi] <= vld_c[gi];
          if (vld_c[gi]) dat_q[gi] <= dat_c[gi];
        end
      end
    end
  endgenerate

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/data_mem.sv
// Single-clock simple dual-port RAM with a registered read port.
// A read and a write to the same address in one cycle returns the old word.
module data_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/amm_ddr_responder.sv
// Avalon-MM memory responder standing in for a DDR controller: init delay,
// waitrequest backpressure, and fixed-latency in-order read returns.
module amm_ddr_responder
  import amm_pkg::*;
#(
  parameter int DDR_DATA_WIDTH  = 64,
  parameter int DDR_ADDR_WIDTH  = 32,
  parameter int MEM_ADDR_WIDTH  = 14,
  parameter int READ_LATENCY    = 4,
  parameter int INIT_CYCLES     = 16,
  parameter int WAIT_PERIOD     = 0,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DDR_ADDR_WIDTH-1:0] amm_addr,
  input  logic [DDR_DATA_WIDTH-1:0] amm_wdata,
  input  logic                      amm_ren,
  input  logic                      amm_wen,
  input  logic [5:0]                amm_burstcount,
  output logic                      amm_wait,
  output logic                      amm_rvalid,
  output logic [DDR_DATA_WIDTH-1:0] amm_rdata,
  output logic                      local_init_done,
  output logic                      err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int WP_W  = (WAIT_PERIOD > 1) ? $clog2(WAIT_PERIOD) : 1;
  localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [WP_W-1:0]  WP_LAST   = WP_W'((WAIT_PERIOD == 0) ? 0 : WAIT_PERIOD - 1);
  localparam logic [15:0]      INIT_LAST = 16'(INIT_CYCLES - 1);

  amm_state_e          state_q, state_d;
  logic [15:0]         init_cnt_q, init_cnt_d;
  logic [WP_W-1:0]     wp_cnt_q, wp_cnt_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic                err_q, err_d;
  logic                rd_pend_q, ram_vld_q;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr_q;
  logic [DDR_DATA_WIDTH-1:0] ram_rdata;
  logic                accept, bad_req, wr_acc, rd_acc;
  logic                unused_addr_bits;

  // Waitrequest depends on registered state only, never on the request inputs.
  assign amm_wait        = (state_q != ST_READY) || (out_q == OUT_MAX);
  assign local_init_done = (state_q != ST_INIT);
  assign err             = err_q;

  assign accept  = ~amm_wait & (amm_ren ^ amm_wen) & (amm_burstcount == AMM_BURST_ONE);
  assign bad_req = ~amm_wait & (amm_ren | amm_wen)
                 & ((amm_ren & amm_wen) | (amm_burstcount != AMM_BURST_ONE));
  assign wr_acc  = accept & amm_wen;
  assign rd_acc  = accept & amm_ren;
  assign unused_addr_bits = ^amm_addr[DDR_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wp_cnt_d   = wp_cnt_q;
    out_d      = out_q;
    err_d      = err_q | bad_req;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = ST_READY;
        else init_cnt_d = init_cnt_q + 16'd1;
      end
      ST_STALL: state_d = ST_READY;
      default:  state_d = state_q;
    endcase

    if ((WAIT_PERIOD != 0) && accept) begin
      if (wp_cnt_q == WP_LAST) begin
        wp_cnt_d = '0;
        state_d  = ST_STALL;
      end else begin
        wp_cnt_d = wp_cnt_q + WP_W'(1);
      end
    end

    case ({rd_acc, amm_rvalid})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wp_cnt_q   <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      ram_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wp_cnt_q   <= wp_cnt_d;
      out_q      <= out_d;
      err_q      <= err_d;
      rd_pend_q  <= rd_acc;
      ram_vld_q  <= rd_pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) rd_addr_q <= amm_addr[MEM_ADDR_WIDTH-1:0];
  end

  // Write gated by reset: state may still read READY in the reset cycle.
  data_mem #(
    .DATA_WIDTH (DDR_DATA_WIDTH),
    .ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc & rst),
    .waddr_i (amm_addr[MEM_ADDR_WIDTH-1:0]),
    .wdata_i (amm_wdata),
    .re_i    (rd_pend_q),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  // Address capture and RAM read take two edges; the pipe supplies the rest.
  amm_rd_pipe #(
    .WIDTH (DDR_DATA_WIDTH),
    .DEPTH (READ_LATENCY - 1)
  ) u_pipe (
    .clk         (clk),
    .rst_n_i     (rst),
    .in_valid_i  (ram_vld_q),
    .in_data_i   (ram_rdata),
    .out_valid_o (amm_rvalid),
    .out_data_o  (amm_rdata)
  );

endmodule

// File: tb/tb_amm_ddr_responder.sv
// Self-checking bench for amm_ddr_responder: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_amm_ddr_responder;

  localparam int DW   = 64;
  localparam int AW   = 32;
  localparam int MAW  = 8;
  localparam int LAT  = 4;
  localparam int INIT = 16;
  localparam int WP   = 3;
  localparam int MAXO = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] amm_addr;
  logic [DW-1:0] amm_wdata;
  logic          amm_ren, amm_wen;
  logic [5:0]    amm_burstcount;
  logic          amm_wait, amm_rvalid, local_init_done, err;
  logic [DW-1:0] amm_rdata;

  amm_ddr_responder #(
    .DDR_DATA_WIDTH (DW), .DDR_ADDR_WIDTH (AW), .MEM_ADDR_WIDTH (MAW),
    .READ_LATENCY (LAT), .INIT_CYCLES (INIT), .WAIT_PERIOD (WP),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk (clk), .rst (rst), .amm_addr (amm_addr), .amm_wdata (amm_wdata),
    .amm_ren (amm_ren), .amm_wen (amm_wen), .amm_burstcount (amm_burstcount),
    .amm_wait (amm_wait), .amm_rvalid (amm_rvalid), .amm_rdata (amm_rdata),
    .local_init_done (local_init_done), .err (err)
  );

  always #5 clk = ~clk;

  // Reference model: reads are queued with the edge number they are due on.
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  rd_t           pend_q[$];
  logic [DW-1:0] mem_m [2**MAW];
  logic [DW-1:0] rdata_m;
  bit            init_done_m, stall_m, err_m, rvalid_m, last_pres;
  int            out_m, rel_m, n_acc, cyc;
  int            n_cmp, n_bad;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    out_m = 0; rel_m = 0; n_acc = 0;
    init_done_m = 0; stall_m = 0; err_m = 0; rvalid_m = 0;
    rdata_m = '0;
  endtask

  // One clock cycle: compare outputs, then advance the model across the edge.
  task automatic step();
    bit exp_wait, pres, acc;
    logic [MAW-1:0] a;
    exp_wait = !init_done_m || stall_m || (out_m == MAXO);
    check("wait",   DW'(amm_wait),        DW'(exp_wait));
    check("rvalid", DW'(amm_rvalid),      DW'(rvalid_m));
    check("rdata",  amm_rdata,            rdata_m);
    check("err",    DW'(err),             DW'(err_m));
    check("init",   DW'(local_init_done), DW'(init_done_m));
    pres = !exp_wait && (amm_ren || amm_wen);
    acc  = pres && (amm_ren != amm_wen) && (amm_burstcount == 6'd1);
    a    = amm_addr[MAW-1:0];
    last_pres = pres;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      if (rel_m < INIT) rel_m++;
      init_done_m = (rel_m >= INIT);
      if (pres && !acc) err_m = 1;
      if (acc && amm_wen) mem_m[a] = amm_wdata;
      if (acc && amm_ren) pend_q.push_back('{due: cyc + LAT, data: mem_m[a]});
      out_m = out_m + ((acc && amm_ren) ? 1 : 0) - (rvalid_m ? 1 : 0);
      stall_m = 0;
      if (acc) begin
        n_acc++;
        if (n_acc % WP == 0) stall_m = 1;
      end
      rvalid_m = 0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        rvalid_m = 1;
        rdata_m  = pend_q[0].data;
        void'(pend_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    amm_ren = 0; amm_wen = 0; amm_burstcount = 6'd1;
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold a command stable until the responder samples it with waitrequest low.
  task automatic issue(input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [5:0] bc);
    int n;
    amm_ren = r; amm_wen = w; amm_addr = a; amm_wdata = d; amm_burstcount = bc;
    n = 0;
    last_pres = 0;
    while (!last_pres && n < 64) begin
      step();
      n++;
    end
    check("accept_timeout", DW'(last_pres), DW'(1));
    amm_ren = 0; amm_wen = 0; amm_burstcount = 6'd1;
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [3:0] nib;
    nib = 4'(k);
    return {16{nib}};
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    model_reset();
    rst = 0; amm_ren = 0; amm_wen = 0; amm_burstcount = 6'd1;
    amm_addr = '0; amm_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    step(); step();
    rst = 1;
    idle(INIT + 4);

    for (int i = 0; i < 4; i++) issue(0, 1, AW'(i), pat(i + 1), 6'd1);
    for (int i = 3; i >= 0; i--) issue(1, 0, AW'(i), '0, 6'd1);
    idle(10);

    for (int i = 4; i < 32; i++) issue(0, 1, AW'(i), {$urandom(), $urandom()}, 6'd1);
    for (int t = 0; t < 300; t++) begin
      int kind;
      logic [AW-1:0] a;
      kind = $urandom_range(0, 3);
      a = {$urandom()} & 32'hFFFF_FF00;
      a[MAW-1:0] = MAW'($urandom_range(4, 31));
      if (kind == 0)      idle($urandom_range(1, 3));
      else if (kind == 1) issue(0, 1, a, {$urandom(), $urandom()}, 6'd1);
      else                issue(1, 0, a, '0, 6'd1);
    end
    idle(10);

    issue(1, 1, AW'(5), 64'hDEAD_BEEF_DEAD_BEEF, 6'd1);
    idle(3);
    issue(1, 0, AW'(5), '0, 6'd1);
    idle(8);
    issue(1, 0, AW'(6), '0, 6'd2);
    idle(8);

    issue(1, 0, AW'(8), '0, 6'd1);
    issue(1, 0, AW'(9), '0, 6'd1);
    issue(1, 0, AW'(10), '0, 6'd1);
    rst = 0;
    step();
    rst = 1;
    idle(INIT + 4);
    issue(1, 0, AW'(0), '0, 6'd1);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
